rom_load_ctrl: RTL and testbench

Sequencer between the HPS ioctl download port and the game core's ROM write ports. It decodes the linear download stream into up to four contiguous ROM regions and produces registered one-hot write strobes with a region-relative address. It holds the core in reset from power-up, through every download, and for a fixed settle time afterwards. It reports sticky load-complete and load-error status to the top level.

---
 rtl/rom_load_ctrl.sv | 152 +++++++++++++++
 tb/tb_rom_load_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_load_ctrl.sv
// ROM download sequencer: splits the hps_io ioctl byte stream into up to four
// contiguous ROM regions and keeps the game core in reset around each download.
module rom_load_ctrl #(
   parameter int unsigned R0_SIZE  = 65536,
   parameter int unsigned R1_SIZE  = 65536,
   parameter int unsigned R2_SIZE  = 0,
   parameter int unsigned R3_SIZE  = 0,
   parameter int unsigned RST_HOLD = 16
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic [3:0]  rom_we,
   output logic [16:0] rom_addr,
   output logic [7:0]  rom_data,
   output logic        core_reset,
   output logic        load_done,
   output logic        load_err
);

   localparam logic [31:0] B1    = 32'(R0_SIZE);
   localparam logic [31:0] B2    = B1 + 32'(R1_SIZE);
   localparam logic [31:0] B3    = B2 + 32'(R2_SIZE);
   localparam logic [31:0] TOTAL = B3 + 32'(R3_SIZE);
   localparam logic [31:0] BOUND [5] = '{32'd0, B1, B2, B3, TOTAL};

   typedef enum logic [2:0] {EMPTY, LOAD, HOLD, RUN, FAIL} state_t;

   state_t        state_reg, state_next;
   logic [17:0]   byte_cnt_reg;
   logic [15:0]   hold_cnt_reg;
   logic          overflow_reg;
   logic [3:0]    rom_we_reg;
   logic [16:0]   rom_addr_reg;
   logic [7:0]    rom_data_reg;
   logic          core_reset_reg;
   logic          load_done_reg;
   logic          load_err_reg;

   logic [31:0]   addr_ext;
   logic [3:0]    hit;
   logic [16:0]   offs [4];
   logic [16:0]   wr_addr;
   logic          in_range;
   logic          wr_accept;
   logic          entering_load;
   logic          count_ok;

   assign addr_ext = {7'd0, ioctl_addr};

   // A zero-size region has equal lower and upper bounds, so it can never hit.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_region
         if (gi == 0) begin : g_first
            assign hit[gi] = (addr_ext < BOUND[gi+1]);
         end else begin : g_rest
            assign hit[gi] = (addr_ext >= BOUND[gi]) && (addr_ext < BOUND[gi+1]);
         end
         assign offs[gi] = ioctl_addr[16:0] - BOUND[gi][16:0];
      end
   endgenerate

   always_comb begin
      wr_addr = '0;
      for (int i = 0; i < 4; i++) begin
         if (hit[i]) begin
            wr_addr = wr_addr | offs[i];
         end
      end
   end

   assign in_range      = |hit;
   assign wr_accept     = (state_reg == LOAD) && ioctl_download && ioctl_wr;
   assign entering_load = (state_next == LOAD) && (state_reg != LOAD);
   assign count_ok      = ({14'd0, byte_cnt_reg} == TOTAL) && !overflow_reg;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         EMPTY: if (ioctl_download) state_next = LOAD;
         LOAD:  if (!ioctl_download) state_next = count_ok ? HOLD : FAIL;
         HOLD: begin
            if (ioctl_download)           state_next = LOAD;
            else if (hold_cnt_reg <= 16'd1) state_next = RUN;
         end
         RUN:   if (ioctl_download) state_next = LOAD;
         FAIL:  if (ioctl_download) state_next = LOAD;
         default: state_next = EMPTY;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_reg      <= EMPTY;
         byte_cnt_reg   <= '0;
         hold_cnt_reg   <= '0;
         overflow_reg   <= 1'b0;
         rom_we_reg     <= '0;
         rom_addr_reg   <= '0;
         rom_data_reg   <= '0;
         core_reset_reg <= 1'b1;
         load_done_reg  <= 1'b0;
         load_err_reg   <= 1'b0;
      end else begin
         state_reg      <= state_next;
         // hit is all-zero for out-of-range addresses, so no strobe leaks out
         rom_we_reg     <= wr_accept ? hit : 4'b0000;
         core_reset_reg <= (state_next != RUN);

         if (wr_accept && in_range) begin
            rom_addr_reg <= wr_addr;
            rom_data_reg <= ioctl_dout;
         end

         if (entering_load) begin
            byte_cnt_reg  <= '0;
            overflow_reg  <= 1'b0;
            load_done_reg <= 1'b0;
            load_err_reg  <= 1'b0;
         end else if (wr_accept) begin
            if (!in_range) begin
               overflow_reg <= 1'b1;
            end else if (byte_cnt_reg != '1) begin
               byte_cnt_reg <= byte_cnt_reg + 18'd1;
            end
         end

         if (state_reg == LOAD && state_next == FAIL) begin
            load_err_reg <= 1'b1;
         end

         if (state_reg == LOAD && state_next == HOLD) begin
            load_done_reg <= 1'b1;
            hold_cnt_reg  <= 16'(RST_HOLD);
         end else if (state_reg == HOLD) begin
            hold_cnt_reg  <= hold_cnt_reg - 16'd1;
         end
      end
   end

   assign rom_we     = rom_we_reg;
   assign rom_addr   = rom_addr_reg;
   assign rom_data   = rom_data_reg;
   assign core_reset = core_reset_reg;
   assign load_done  = load_done_reg;
   assign load_err   = load_err_reg;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Scoreboard bench for rom_load_ctrl: a scaled two-region instance and a
// sparse four-region instance share the byte bus but have separate download/reset.
module tb_rom_load_ctrl;

   localparam int A_R0 = 1024, A_R1 = 1024, A_HOLD = 16;
   localparam int A_TOTAL = A_R0 + A_R1;
   localparam int B_R0 = 4, B_R1 = 0, B_R2 = 4, B_R3 = 4, B_HOLD = 1;
   localparam int B_TOTAL = B_R0 + B_R1 + B_R2 + B_R3;

   logic        clk_sys = 1'b0;
   logic        rst_a, rst_b, dl_a, dl_b, wr;
   logic [24:0] addr;
   logic [7:0]  dout;

   logic [3:0]  we_a, we_b;
   logic [16:0] ra_a, ra_b;
   logic [7:0]  rd_a, rd_b;
   logic        cr_a, cr_b, done_a, done_b, err_a, err_b;

   typedef struct packed {
      logic [3:0]  we;
      logic [16:0] addr;
      logic [7:0]  data;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk_sys = ~clk_sys;

   rom_load_ctrl #(.R0_SIZE(A_R0), .R1_SIZE(A_R1), .R2_SIZE(0), .R3_SIZE(0),
                   .RST_HOLD(A_HOLD)) dut_a (
      .clk_sys(clk_sys), .reset(rst_a), .ioctl_download(dl_a), .ioctl_wr(wr),
      .ioctl_addr(addr), .ioctl_dout(dout), .rom_we(we_a), .rom_addr(ra_a),
      .rom_data(rd_a), .core_reset(cr_a), .load_done(done_a), .load_err(err_a));

   rom_load_ctrl #(.R0_SIZE(B_R0), .R1_SIZE(B_R1), .R2_SIZE(B_R2), .R3_SIZE(B_R3),
                   .RST_HOLD(B_HOLD)) dut_b (
      .clk_sys(clk_sys), .reset(rst_b), .ioctl_download(dl_b), .ioctl_wr(wr),
      .ioctl_addr(addr), .ioctl_dout(dout), .rom_we(we_b), .rom_addr(ra_b),
      .rom_data(rd_b), .core_reset(cr_b), .load_done(done_b), .load_err(err_b));

   // Strobe monitors: every strobe must match the oldest outstanding write.
   always @(posedge clk_sys) begin : mon_a
      exp_t e;
      #1;
      if (we_a !== 4'b0000) begin
         checks++;
         if (qa.size() == 0) begin
            errors++;
            $display("FAIL strobe_a unexpected: we=%b addr=%0d data=%h, required no strobe",
                     we_a, ra_a, rd_a);
         end else begin
            e = qa.pop_front();
            if ({we_a, ra_a, rd_a} !== e) begin
               errors++;
               $display("FAIL strobe_a: got we=%b addr=%0d data=%h, required we=%b addr=%0d data=%h",
                        we_a, ra_a, rd_a, e.we, e.addr, e.data);
            end
         end
      end
   end

   always @(posedge clk_sys) begin : mon_b
      exp_t e;
      #1;
      if (we_b !== 4'b0000) begin
         checks++;
         if (qb.size() == 0) begin
            errors++;
            $display("FAIL strobe_b unexpected: we=%b addr=%0d data=%h, required no strobe",
                     we_b, ra_b, rd_b);
         end else begin
            e = qb.pop_front();
            if ({we_b, ra_b, rd_b} !== e) begin
               errors++;
               $display("FAIL strobe_b: got we=%b addr=%0d data=%h, required we=%b addr=%0d data=%h",
                        we_b, ra_b, rd_b, e.we, e.addr, e.data);
            end
         end
      end
   end

   // Reference decode: walk the regions in order, first one containing the offset wins.
   function automatic void model(input int s0, input int s1, input int s2, input int s3,
                                 input int a, output logic [3:0] we, output logic [16:0] off);
      int base, sz;
      we = 4'b0000;
      off = '0;
      base = 0;
      for (int i = 0; i < 4; i++) begin
         sz = (i == 0) ? s0 : (i == 1) ? s1 : (i == 2) ? s2 : s3;
         if (we == 4'b0000 && a >= base && a < base + sz) begin
            we = 4'b0001 << i;
            off = 17'(a - base);
         end
         base += sz;
      end
   endfunction

   // Drives one accepted-write cycle; caller guarantees the DUT is in LOAD.
   task automatic write_byte(input bit sel_b, input int a, input logic [7:0] d);
      logic [3:0]  we;
      logic [16:0] off;
      exp_t        e;
      wr   = 1'b1;
      addr = 25'(a);
      dout = d;
      if (sel_b) model(B_R0, B_R1, B_R2, B_R3, a, we, off);
      else       model(A_R0, A_R1, 0, 0, a, we, off);
      if (we != 4'b0000) begin
         e.we = we; e.addr = off; e.data = d;
         if (sel_b) qb.push_back(e);
         else       qa.push_back(e);
      end
      @(negedge clk_sys);
      wr = 1'b0;
   endtask

   task automatic start_dl(input bit sel_b);
      if (sel_b) dl_b = 1'b1;
      else       dl_a = 1'b1;
      @(negedge clk_sys);
   endtask

   // Counts edges from the first edge that samples download low until core_reset drops.
   task automatic wait_run(input bit sel_b, output int n);
      n = -1;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk_sys);
         #1;
         if ((sel_b ? cr_b : cr_a) == 1'b0) begin
            n = i;
            break;
         end
      end
      @(negedge clk_sys);
   endtask

   task automatic check_queues(input string tag);
      checks++;
      if (qa.size() != 0 || qb.size() != 0) begin
         errors++;
         $display("FAIL %s pending: qa=%0d qb=%0d, required 0 0", tag, qa.size(), qb.size());
      end
   endtask

   task automatic test_reset;
      rst_a = 1'b1; rst_b = 1'b1; dl_a = 1'b0; dl_b = 1'b0; wr = 1'b0;
      addr = '0; dout = '0;
      repeat (3) @(negedge clk_sys);
      checks++;
      if ({we_a, ra_a, rd_a, cr_a, done_a, err_a} !== {4'b0, 17'b0, 8'b0, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_a: we=%b addr=%0d data=%h cr=%b done=%b err=%b, required 0 0 00 1 0 0",
                  we_a, ra_a, rd_a, cr_a, done_a, err_a);
      end
      checks++;
      if ({we_b, ra_b, rd_b, cr_b, done_b, err_b} !== {4'b0, 17'b0, 8'b0, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_b: we=%b addr=%0d data=%h cr=%b done=%b err=%b, required 0 0 00 1 0 0",
                  we_b, ra_b, rd_b, cr_b, done_b, err_b);
      end
      rst_a = 1'b0; rst_b = 1'b0;
      repeat (10) @(negedge clk_sys);
      checks++;
      if (cr_a !== 1'b1 || cr_b !== 1'b1) begin
         errors++;
         $display("FAIL empty_core_reset: a=%b b=%b, required 1 1", cr_a, cr_b);
      end
      $display("test_reset done");
   endtask

   task automatic test_good_load;
      int n;
      start_dl(0);
      for (int a = 0; a < A_TOTAL; a++) write_byte(0, a, 8'(a * 7 + 3));
      dl_a = 1'b0;
      wait_run(0, n);
      checks++;
      if (n != A_HOLD) begin
         errors++;
         $display("FAIL good_hold: core_reset fell after %0d cycles, required %0d", n, A_HOLD);
      end
      checks++;
      if (done_a !== 1'b1 || err_a !== 1'b0) begin
         errors++;
         $display("FAIL good_status: done=%b err=%b, required 1 0", done_a, err_a);
      end
      check_queues("good_load");
      $display("test_good_load: %0d bytes, release after %0d cycles", A_TOTAL, n);
   endtask

   task automatic test_short_load;
      start_dl(0);
      for (int a = 0; a < 1000; a++) write_byte(0, a, 8'(a ^ 8'h5a));
      dl_a = 1'b0;
      repeat (50) @(negedge clk_sys);
      checks++;
      if (cr_a !== 1'b1 || done_a !== 1'b0 || err_a !== 1'b1) begin
         errors++;
         $display("FAIL short_status: cr=%b done=%b err=%b, required 1 0 1", cr_a, done_a, err_a);
      end
      check_queues("short_load");
      $display("test_short_load: 1000 bytes");
   endtask

   task automatic test_overflow;
      start_dl(0);
      for (int a = 0; a < A_TOTAL; a++) write_byte(0, a, 8'(a + 1));
      write_byte(0, A_TOTAL, 8'hee);
      write_byte(0, 25'h1ffffff, 8'hdd);
      dl_a = 1'b0;
      repeat (30) @(negedge clk_sys);
      checks++;
      if (cr_a !== 1'b1 || done_a !== 1'b0 || err_a !== 1'b1) begin
         errors++;
         $display("FAIL overflow_status: cr=%b done=%b err=%b, required 1 0 1", cr_a, done_a, err_a);
      end
      check_queues("overflow");
      $display("test_overflow: %0d bytes plus 2 out-of-range", A_TOTAL);
   endtask

   task automatic test_reload;
      int n;
      start_dl(0);
      for (int a = 0; a < A_TOTAL; a++) write_byte(0, a, 8'(a * 3));
      dl_a = 1'b0;
      wait_run(0, n);
      checks++;
      if (n != A_HOLD) begin
         errors++;
         $display("FAIL reload_first_hold: %0d cycles, required %0d", n, A_HOLD);
      end
      // stray strobes with download low must not reach the ROMs
      wr = 1'b1; addr = 25'd5; dout = 8'h77;
      repeat (3) @(negedge clk_sys);
      wr = 1'b0;
      dl_a = 1'b1;
      @(posedge clk_sys);
      #1;
      checks++;
      if (cr_a !== 1'b1 || done_a !== 1'b0 || err_a !== 1'b0) begin
         errors++;
         $display("FAIL reload_entry: cr=%b done=%b err=%b, required 1 0 0", cr_a, done_a, err_a);
      end
      @(negedge clk_sys);
      for (int a = A_TOTAL - 1; a >= 0; a--) write_byte(0, a, 8'(a + 9));
      // write coinciding with the download falling edge is dropped
      dl_a = 1'b0; wr = 1'b1; addr = 25'd0; dout = 8'h11;
      wait_run(0, n);
      wr = 1'b0;
      checks++;
      if (n != A_HOLD) begin
         errors++;
         $display("FAIL reload_hold: %0d cycles, required %0d", n, A_HOLD);
      end
      checks++;
      if (done_a !== 1'b1 || err_a !== 1'b0) begin
         errors++;
         $display("FAIL reload_status: done=%b err=%b, required 1 0", done_a, err_a);
      end
      check_queues("reload");
      $display("test_reload: reverse-order reload, release after %0d cycles", n);
   endtask

   task automatic test_reset_mid_load;
      start_dl(0);
      for (int a = 0; a < 500; a++) write_byte(0, a, 8'(a));
      rst_a = 1'b1;
      @(posedge clk_sys);
      #1;
      checks++;
      if ({we_a, ra_a, rd_a, cr_a, done_a, err_a} !== {4'b0, 17'b0, 8'b0, 1'b1, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL midload_reset: we=%b addr=%0d data=%h cr=%b done=%b err=%b, required 0 0 00 1 0 0",
                  we_a, ra_a, rd_a, cr_a, done_a, err_a);
      end
      @(negedge clk_sys);
      rst_a = 1'b0;
      @(negedge clk_sys);
      for (int a = 500; a < A_TOTAL; a++) write_byte(0, a, 8'(a));
      dl_a = 1'b0;
      repeat (30) @(negedge clk_sys);
      checks++;
      if (cr_a !== 1'b1 || done_a !== 1'b0 || err_a !== 1'b1) begin
         errors++;
         $display("FAIL midload_status: cr=%b done=%b err=%b, required 1 0 1", cr_a, done_a, err_a);
      end
      check_queues("reset_mid_load");
      $display("test_reset_mid_load: reset at byte 500");
   endtask

   task automatic test_sparse_regions;
      int n;
      start_dl(1);
      for (int a = 0; a < B_TOTAL; a++) write_byte(1, a, 8'(8'hc0 + a));
      dl_b = 1'b0;
      wait_run(1, n);
      checks++;
      if (n != B_HOLD) begin
         errors++;
         $display("FAIL sparse_hold: %0d cycles, required %0d", n, B_HOLD);
      end
      checks++;
      if (done_b !== 1'b1 || err_b !== 1'b0) begin
         errors++;
         $display("FAIL sparse_status: done=%b err=%b, required 1 0", done_b, err_b);
      end
      check_queues("sparse");
      $display("test_sparse_regions: %0d bytes, release after %0d cycles", B_TOTAL, n);
   endtask

   initial begin
      @(negedge clk_sys);
      test_reset();
      test_good_load();
      test_short_load();
      test_overflow();
      test_reload();
      test_reset_mid_load();
      test_sparse_regions();
      repeat (3) @(negedge clk_sys);
      check_queues("final");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
